// File: rtl/pomodoro_timer_ctrl.sv
// Pomodoro sequencer: BCD mm:ss countdown over a work / short / long schedule.
// Drives the four display digits, phase and completed-work count.
module pomodoro_timer_ctrl #(
  parameter int CLK_FREQ           = 50000000,
  parameter int WORK_MIN           = 25,
  parameter int SHORT_BREAK_MIN    = 5,
  parameter int LONG_BREAK_MIN     = 15,
  parameter int CYCLES_BEFORE_LONG = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pause,
  input  logic       skip,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] phase,
  output logic       running,
  output logic [2:0] work_count,
  output logic       phase_done
);

  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [3:0] WT = 4'(WORK_MIN / 10);
  localparam logic [3:0] WO = 4'(WORK_MIN % 10);
  localparam logic [3:0] ST = 4'(SHORT_BREAK_MIN / 10);
  localparam logic [3:0] SO = 4'(SHORT_BREAK_MIN % 10);
  localparam logic [3:0] LT = 4'(LONG_BREAK_MIN / 10);
  localparam logic [3:0] LO = 4'(LONG_BREAK_MIN % 10);
  localparam logic [2:0] NLONG = 3'(CYCLES_BEFORE_LONG);

  typedef enum logic [1:0] {
    WORK        = 2'd0,
    SHORT_BREAK = 2'd1,
    LONG_BREAK  = 2'd2
  } phase_e;

  phase_e        ph, ph_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    mt_n, mo_n, st_n, so_n;
  logic          run_n, done_n;
  logic [2:0]    wc_n;
  logic          tick, zero, end_ev;

  assign phase  = ph;
  assign tick   = running && (presc == PMAX);
  assign zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign end_ev = skip || (tick && zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      ph         <= WORK;
      presc      <= '0;
      running    <= 1'b0;
      work_count <= 3'd0;
      phase_done <= 1'b0;
      min_tens   <= WT;
      min_ones   <= WO;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
    end else begin
      ph         <= ph_n;
      presc      <= presc_n;
      running    <= run_n;
      work_count <= wc_n;
      phase_done <= done_n;
      min_tens   <= mt_n;
      min_ones   <= mo_n;
      sec_tens   <= st_n;
      sec_ones   <= so_n;
    end
  end

  always_comb begin
    ph_n    = ph;
    presc_n = presc;
    run_n   = running;
    wc_n    = work_count;
    done_n  = 1'b0;
    mt_n    = min_tens;
    mo_n    = min_ones;
    st_n    = sec_tens;
    so_n    = sec_ones;
    if (end_ev) begin
      presc_n = '0;
      run_n   = 1'b0;
      done_n  = 1'b1;
      st_n    = 4'd0;
      so_n    = 4'd0;
      unique case (ph)
        WORK: begin
          if (work_count + 3'd1 == NLONG) begin
            ph_n = LONG_BREAK;
            wc_n = 3'd0;
            mt_n = LT;
            mo_n = LO;
          end else begin
            ph_n = SHORT_BREAK;
            wc_n = work_count + 3'd1;
            mt_n = ST;
            mo_n = SO;
          end
        end
        default: begin
          ph_n = WORK;
          mt_n = WT;
          mo_n = WO;
        end
      endcase
    end else begin
      if (start_pause) run_n = !running;
      if (running) presc_n = tick ? '0 : presc + PONE;
      // borrow chain; zero is excluded above so min_tens is nonzero on full borrow
      if (tick) begin
        if (sec_ones != 4'd0) begin
          so_n = sec_ones - 4'd1;
        end else begin
          so_n = 4'd9;
          if (sec_tens != 4'd0) begin
            st_n = sec_tens - 4'd1;
          end else begin
            st_n = 4'd5;
            if (min_ones != 4'd0) begin
              mo_n = min_ones - 4'd1;
            end else begin
              mo_n = 4'd9;
              mt_n = min_tens - 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pomodoro_timer_ctrl.sv
// Directed bench for pomodoro_timer_ctrl at CLK_FREQ=4 and short phases.
// Inputs change and outputs are sampled on the falling edge.
module tb_pomodoro_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, start_pause, skip;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] phase;
  logic       running, phase_done;
  logic [2:0] work_count;
  int checks = 0;
  int errors = 0;

  pomodoro_timer_ctrl #(
    .CLK_FREQ(4),
    .WORK_MIN(1),
    .SHORT_BREAK_MIN(2),
    .LONG_BREAK_MIN(3),
    .CYCLES_BEFORE_LONG(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_pause(start_pause),
    .skip(skip),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .phase(phase),
    .running(running),
    .work_count(work_count),
    .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  function automatic int digits();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic sp, input logic sk, input logic rs);
    start_pause = sp;
    skip        = sk;
    reset       = rs;
    @(negedge clk);
    start_pause = 1'b0;
    skip        = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int d, input int ph,
                         input int run, input int wc, input int dn);
    chk({tag, "_dig"}, digits(), d);
    chk({tag, "_ph"}, int'(phase), ph);
    chk({tag, "_run"}, int'(running), run);
    chk({tag, "_wc"}, int'(work_count), wc);
    chk({tag, "_done"}, int'(phase_done), dn);
  endtask

  initial begin
    reset = 1'b1;
    start_pause = 1'b0;
    skip = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk_all("rst", 'h0100, 0, 0, 0, 0);
    cyc(20);
    chk_all("idle", 'h0100, 0, 0, 0, 0);

    pulse(1, 0, 0);
    chk("start_run", int'(running), 1);
    cyc(3);
    chk("pre_tick", digits(), 'h0100);
    cyc(1);
    chk("tick1", digits(), 'h0059);
    cyc(36);
    chk("sec_borrow", digits(), 'h0050);
    cyc(48);
    chk("at38", digits(), 'h0038);
    cyc(3);
    // pause lands on the tick edge: decrement taken, prescaler wraps to 0
    pulse(1, 0, 0);
    chk("pause_dig", digits(), 'h0037);
    chk("pause_run", int'(running), 0);
    cyc(100);
    chk("pause_hold", digits(), 'h0037);
    pulse(1, 0, 0);
    chk("resume_run", int'(running), 1);
    cyc(3);
    chk("resume_3", digits(), 'h0037);
    cyc(1);
    chk("resume_4", digits(), 'h0036);

    cyc(144);
    chk_all("zero", 'h0000, 0, 1, 0, 0);
    cyc(3);
    chk("zero_hold", digits(), 'h0000);
    cyc(1);
    chk_all("expire", 'h0200, 1, 0, 1, 1);
    cyc(1);
    chk("done_1cyc", int'(phase_done), 0);

    pulse(0, 1, 0);
    chk_all("skip_short", 'h0100, 0, 0, 1, 1);
    cyc(1);
    chk("skip_done_1cyc", int'(phase_done), 0);
    pulse(1, 0, 0);
    cyc(243);
    chk_all("w2_zero", 'h0000, 0, 1, 1, 0);
    cyc(1);
    chk_all("long", 'h0300, 2, 0, 0, 1);

    pulse(1, 0, 0);
    cyc(672);
    chk("at12", digits(), 'h0012);
    cyc(3);
    pulse(1, 1, 0);
    chk_all("skip_sp", 'h0100, 0, 0, 0, 1);

    pulse(0, 1, 0);
    chk_all("to_short", 'h0200, 1, 0, 1, 1);
    pulse(1, 0, 0);
    cyc(9);
    chk("brk_run", digits(), 'h0158);
    pulse(0, 1, 1);
    chk_all("mid_rst", 'h0100, 0, 0, 0, 0);
    cyc(6);
    chk_all("post_rst", 'h0100, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
